token_ratio_gate: RTL
=====================

// Module: token_ratio_gate
//
// PURPOSE
//  Programmable serial token thinner: of every cfg_window incoming '1' tokens on
//  a, passes the last cfg_keep to b and drops the rest. Zeros pass through as zeros.
//  Includes the controller that accepts new ratios via a valid/ready handshake.
//  New ratios apply only at window boundaries, so no window is ever split between
//  two ratios. Default after reset is keep=1/window=2, i.e. halving.
//  Sits between a serial token source and its consumer.
//
// PARAMETERS
//  W            4   width of window/keep/index fields; window range 0..2**W-1
//  RST_KEEP     1   keep value loaded on reset
//  RST_WINDOW   2   window value loaded on reset
//
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst          in   1   synchronous reset, active-high
//  a            in   1   serial token input; '1' = one token
//  b            out  1   thinned token output, same cycle as a
//  clear        in   1   restart current window (idx <- 0); config unaffected
//  cfg_valid    in   1   new ratio offered
//  cfg_ready    out  1   controller can accept a ratio
//  cfg_keep     in   W   tokens passed per window
//  cfg_window   in   W   tokens per window
//  idx          out  W   tokens already seen in the current window
//  cfg_pending  out  1   accepted ratio waiting for a boundary
//
// BEHAVIOUR
//  - Reset (sync): keep=RST_KEEP, window=RST_WINDOW, idx=0, state=RUN, cfg_ready=1,
//    cfg_pending=0. b=0 whenever rst=1.
//  - Gate (combinational, 0 latency):
//      b = a & !rst & (window != 0) & (idx >= window - keep).
//  - Index: on a=1 and window!=0: idx <= (idx == window-1) ? 0 : idx+1.
//    clear=1 forces idx<=0 and wins over a. The token in the clear cycle is
//    still gated with the old idx.
//  - Clamp on accept: keep_eff = min(cfg_keep, cfg_window).
//    cfg_window=0 is legal: b stuck 0, idx held 0.
//  - FSM, 2 states:
//      RUN:  cfg_ready=1. On cfg_valid, latch {keep_eff, cfg_window} into the
//            shadow register and go to PEND.
//      PEND: cfg_ready=0, cfg_pending=1. At the first edge where idx_next==0
//            (wrap, clear, or idx==0 with a=0): copy shadow -> active, go to RUN.
//  - A token in the apply cycle is gated with the OLD ratio. The new ratio governs
//    the cycle after the edge.
//  - Minimum accept-to-apply time is 1 edge. A window never mixes ratios.
//  - cfg_valid while cfg_ready=0 is ignored; the source must hold it.
//  - rst mid-window or in PEND discards the shadow and returns to the RST_* ratio.
//  - keep=0: all tokens dropped. keep=window: all tokens passed.
//    window=1: idx stays 0; b = a if keep=1.
//  - Arithmetic: unsigned W bits; window-keep never underflows because of the clamp.
//
// STRUCTURE
//  - token_pkg: W default, typedef logic [W-1:0] tok_cnt_t,
//    typedef enum logic {RUN, PEND} ratio_state_e, reset constants.
//  - Sub-module token_window_counter (idx register, wrap, clear, idx_next output),
//    instantiated once.
//  - The FSM, shadow/active registers and gate stay in the top module.
//
// TESTING
//  1. Default after reset, no cfg:
//     a=110_011_101_000_1111 -> b=010_001_001_000_0101.
//  2. cfg keep=2 window=3 accepted at idx=0, a=0 one cycle, then a=111111
//     -> b=011011; idx cycles 0,1,2,0,1,2.
//  3. Default ratio, a=1 (idx=1), then cfg keep=3 window=3. The accept cycle has
//     a=0, so the ratio stays pending. Next a=1 wraps, gets b=1 (old ratio), and
//     applies the config. Following a=111 -> b=111. cfg_ready is 0 from the accept
//     edge until the apply edge.
//  4. Clamp: cfg keep=7 window=4, stream a=1111 -> b=1111. cfg_window=0, a=1111 -> b=0000, idx=0.
//  5. Default ratio, a=1 (idx=1), clear=1 with a=1 -> b=1, idx=0; next a=1 -> b=0.
//  6. Default ratio, cfg keep=0 window=3 accepted mid-window (idx=1), then rst=1 for
//     one cycle -> b=0, cfg_pending=0, cfg_ready=1. Then a=11 -> b=01 (halving restored).

Source files
------------

// File: rtl/token_pkg.sv
// token_pkg: shared width, counter type, ratio FSM states and reset ratio for the token thinner
// Contents: TOK_W default field width, tok_cnt_t, ratio_state_e, TOK_RST_KEEP/TOK_RST_WINDOW
package token_pkg;
   localparam int TOK_W          = 4;
   localparam int TOK_RST_KEEP   = 1;
   localparam int TOK_RST_WINDOW = 2;
   typedef logic [TOK_W-1:0] tok_cnt_t;
   typedef enum logic {RUN, PEND} ratio_state_e;
endpackage

// File: rtl/token_window_counter.sv
// token_window_counter: position of the current token inside its window
// Ports: clk, rst (sync, active-high), a (token in), clear (restart window),
//        window (active window size), idx (tokens seen so far), idx_next (value loaded at next edge)
module token_window_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         a,
   input  logic         clear,
   input  logic [W-1:0] window,
   output logic [W-1:0] idx,
   output logic [W-1:0] idx_next
);
   logic [W-1:0] r_idx;
   logic         w_wrap;
   assign idx = r_idx;
   assign w_wrap = r_idx == window - W'(1);
   // a zero window freezes the count, so it never leaves 0
   assign idx_next = (rst | clear) ? '0 :
                     (a && window != '0) ? (w_wrap ? '0 : r_idx + W'(1)) : r_idx;
   always_ff @(posedge clk) begin
      if (rst) r_idx <= '0;
      else     r_idx <= idx_next;
   end
endmodule

// File: rtl/token_ratio_gate.sv
// token_ratio_gate: of every window '1' tokens on a, pass the last keep to b; ratio changes only at window boundaries
// Ports: clk, rst (sync, active-high), a (token in), b (thinned token out, same cycle),
//        clear (restart window), cfg_valid/cfg_ready (ratio handshake), cfg_keep/cfg_window (new ratio),
//        idx (position in window), cfg_pending (accepted ratio awaiting a boundary)
module token_ratio_gate
   import token_pkg::*;
#(
   parameter int W          = TOK_W,
   parameter int RST_KEEP   = TOK_RST_KEEP,
   parameter int RST_WINDOW = TOK_RST_WINDOW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         a,
   output logic         b,
   input  logic         clear,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] cfg_keep,
   input  logic [W-1:0] cfg_window,
   output logic [W-1:0] idx,
   output logic         cfg_pending
);
   ratio_state_e r_state, w_state_next;
   logic [W-1:0] r_keep, r_window, r_sh_keep, r_sh_window;
   logic [W-1:0] w_idx_next, w_keep_eff;
   logic         w_accept, w_apply;

   token_window_counter #(.W(W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .clear    (clear),
      .window   (r_window),
      .idx      (idx),
      .idx_next (w_idx_next)
   );

   // clamping keep to window keeps window-keep from underflowing in the gate
   assign w_keep_eff  = (cfg_keep > cfg_window) ? cfg_window : cfg_keep;
   assign cfg_ready   = r_state == RUN;
   assign cfg_pending = r_state == PEND;
   assign w_accept    = cfg_ready & cfg_valid;
   // a zero next index marks a window boundary: wrap, clear, or idle at 0
   assign w_apply     = cfg_pending & (w_idx_next == '0);
   assign b = a & ~rst & (r_window != '0) & (idx >= r_window - r_keep);

   always_comb begin
      w_state_next = r_state;
      if (w_accept)     w_state_next = PEND;
      else if (w_apply) w_state_next = RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RUN;
         r_keep      <= W'(RST_KEEP);
         r_window    <= W'(RST_WINDOW);
         r_sh_keep   <= W'(RST_KEEP);
         r_sh_window <= W'(RST_WINDOW);
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_sh_keep   <= w_keep_eff;
            r_sh_window <= cfg_window;
         end
         if (w_apply) begin
            r_keep   <= r_sh_keep;
            r_window <= r_sh_window;
         end
      end
   end
endmodule
